maze_map_engine: RTL

- Parametrised successor to the maze map lookup block.
- Holds NUM_MAPS wall bitmaps of ROWS x COLS tiles and selects one as the active map.
- Serves two independent request channels, each with a valid/ready handshake:
  - probe: collision query for NUM_PROBES points per request;
  - line: VGA scan-line wall mask for one pixel row.
- Pixel-to-tile conversion uses sequential repeated-subtraction dividers, so no combinational divide. Also tracks the sticky win flag and per-map start coordinates.

---
 rtl/maze_map_engine_pkg.sv | 35 +++
 rtl/maze_map_engine_if.sv | 27 ++
 rtl/maze_map_engine_tile_divider.sv | 52 +++++
 rtl/maze_map_engine.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_map_engine_pkg.sv
// Shared constants for the maze map engine: default geometry, request FSM states,
// the four standard maze bitmaps and the per-map start positions.
package maze_pkg;

  localparam int TILE_PX_DEF  = 60;
  localparam int COLS_DEF     = 14;
  localparam int ROWS_DEF     = 8;
  localparam int NUM_MAPS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_LOOKUP = 2'd2
  } req_state_e;

  // Leftmost literal bit is column 0; each map exits through the bottom row.
  localparam logic [COLS_DEF-1:0] MAP_ROM [NUM_MAPS_DEF][ROWS_DEF] = '{
    '{14'b11111111111111, 14'b10000000000001, 14'b10111011101101, 14'b10001000100001,
      14'b11101110111011, 14'b10000010000001, 14'b10111110111101, 14'b10000000000000},
    '{14'b11111111111111, 14'b10001000000001, 14'b10101011111101, 14'b10100010000101,
      14'b10111110110101, 14'b10000000100101, 14'b11111110101101, 14'b00000000100001},
    '{14'b11111111111111, 14'b10000100000001, 14'b10110101111101, 14'b10100001000001,
      14'b10101111011111, 14'b10100000010001, 14'b10111111010101, 14'b10000000000100},
    '{14'b11111111111111, 14'b10000001000001, 14'b11110000011101, 14'b10010111000001,
      14'b10010100011111, 14'b10000100000001, 14'b10111101111101, 14'b10000000000001}
  };

  localparam logic [17:0] START_X [NUM_MAPS_DEF] = '{
    {11'd80, 7'd0}, {11'd200, 7'd0}, {11'd80, 7'd0}, {11'd320, 7'd0}
  };
  localparam logic [17:0] START_Y [NUM_MAPS_DEF] = '{
    {11'd80, 7'd0}, {11'd80, 7'd0}, {11'd200, 7'd0}, {11'd140, 7'd0}
  };

endpackage

// File: rtl/maze_map_engine_if.sv
// Probe and scan-line request/response channels of the maze map engine.
interface maze_map_engine_if #(
  parameter int NUM_PROBES = 3,
  parameter int COORD_W    = 11,
  parameter int LINE_W     = 1696
);
  logic                          probe_valid;
  logic                          probe_ready;
  logic [NUM_PROBES*COORD_W-1:0] probe_x;
  logic [NUM_PROBES*COORD_W-1:0] probe_y;
  logic                          result_valid;
  logic [NUM_PROBES-1:0]         result_wall;
  logic                          line_valid_in;
  logic                          line_ready;
  logic [COORD_W-1:0]            line_y;
  logic                          line_valid;
  logic [LINE_W-1:0]             line_data;

  modport master (
    output probe_valid, probe_x, probe_y, line_valid_in, line_y,
    input  probe_ready, result_valid, result_wall, line_ready, line_valid, line_data
  );
  modport slave (
    input  probe_valid, probe_x, probe_y, line_valid_in, line_y,
    output probe_ready, result_valid, result_wall, line_ready, line_valid, line_data
  );
endinterface

// File: rtl/maze_map_engine_tile_divider.sv
// Pixel-to-tile divider: repeated subtraction of TILE_PX, one step per cycle,
// done pulses for one cycle once the remainder drops below TILE_PX.
module tile_divider #(
  parameter int TILE_PX = 60,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] value,
  output logic               done,
  output logic [COORD_W-1:0] quotient
);
  localparam logic [COORD_W-1:0] TILE = COORD_W'(TILE_PX);

  logic [COORD_W-1:0] rem_q, rem_d, quo_q, quo_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = value;
      quo_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_q >= TILE) begin
        rem_d = rem_q - TILE;
        quo_d = quo_q + COORD_W'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  assign done     = busy_q && (rem_q < TILE);
  assign quotient = quo_q;

endmodule

// File: rtl/maze_map_engine.sv
// Maze map engine: active-map select, probe collision queries and VGA line masks.
// Build with MAZE_MAP_WRITE_EN for a writable map store with wr_* ports.
module maze_map_engine
  import maze_pkg::*;
#(
  parameter int TILE_PX    = TILE_PX_DEF,
  parameter int H_SCALE    = 2,
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int NUM_MAPS   = NUM_MAPS_DEF,
  parameter int NUM_PROBES = 3,
  parameter int COORD_W    = 11,
  parameter int X_OFFSET   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_MAPS)-1:0] map_sel,
  input  logic                        map_load,
  maze_map_engine_if.slave            bus,
  output logic                        win,
  output logic [17:0]                 start_x,
  output logic [17:0]                 start_y
`ifdef MAZE_MAP_WRITE_EN
  ,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_MAPS)-1:0] wr_map,
  input  logic [$clog2(ROWS)-1:0]     wr_row,
  input  logic [$clog2(COLS)-1:0]     wr_col,
  input  logic                        wr_val
`endif
);
  localparam int MAP_W  = $clog2(NUM_MAPS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int FIELD  = TILE_PX * H_SCALE;
  localparam int LINE_W = COLS * FIELD + 2 * X_OFFSET;
  localparam int NDIV   = 2 * NUM_PROBES;

  logic [MAP_W-1:0] map_q, map_d;
  logic [17:0]      start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COLS-1:0]  map_rev [ROWS];  // bit c = column c of the active map

`ifdef MAZE_MAP_WRITE_EN
  logic [COLS-1:0] store_q [NUM_MAPS][ROWS];
  logic [COLS-1:0] store_d [NUM_MAPS][ROWS];

  always_comb begin
    store_d = store_q;
    if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS))
      store_d[wr_map][wr_row][COL_W'(COLS-1) - wr_col] = wr_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NUM_MAPS; m++)
        for (int r = 0; r < ROWS; r++)
          store_q[m][r] <= COLS'(MAP_ROM[m][r]);
    end else begin
      store_q <= store_d;
    end
  end
`endif

  always_comb begin
    logic [COLS-1:0] row_word;
    row_word = '0;
    for (int r = 0; r < ROWS; r++) begin
`ifdef MAZE_MAP_WRITE_EN
      row_word = store_q[map_q][r];
`else
      row_word = COLS'(MAP_ROM[map_q][r]);
`endif
      for (int c = 0; c < COLS; c++) map_rev[r][c] = row_word[COLS-1-c];
    end
  end

  // ---------------- dividers: 0..NDIV-1 probe x/y pairs, NDIV line row
  logic [COORD_W-1:0] div_val [NDIV+1];
  logic [COORD_W-1:0] div_quo [NDIV+1];
  logic [NDIV:0]      div_done, div_start;
  logic               p_start, l_start;

  for (genvar i = 0; i < NUM_PROBES; i++) begin : g_pv
    assign div_val[2*i]   = bus.probe_x[i*COORD_W +: COORD_W];
    assign div_val[2*i+1] = bus.probe_y[i*COORD_W +: COORD_W];
  end
  assign div_val[NDIV]   = bus.line_y;
  assign div_start       = {l_start, {NDIV{p_start}}};

  for (genvar k = 0; k <= NDIV; k++) begin : g_div
    tile_divider #(.TILE_PX(TILE_PX), .COORD_W(COORD_W)) u_div (
      .clk(clk), .rst(reset), .start(div_start[k]), .value(div_val[k]),
      .done(div_done[k]), .quotient(div_quo[k])
    );
  end

  // ---------------- probe channel
  req_state_e            p_st_q, p_st_d;
  logic [NDIV-1:0]       p_seen_q, p_seen_d;
  logic [NUM_PROBES-1:0] p_wall, p_exit, res_wall_q, res_wall_d;
  logic                  res_valid_q, res_valid_d, p_all_done, win_q, win_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_st_q <= ST_IDLE;
    else       p_st_q <= p_st_d;
  end

  assign p_all_done = &(p_seen_q | div_done[NDIV-1:0]);

  always_comb begin
    p_st_d = p_st_q;
    case (p_st_q)
      ST_IDLE:   if (bus.probe_valid) p_st_d = ST_DIVIDE;
      ST_DIVIDE: if (p_all_done) p_st_d = ST_LOOKUP;
      ST_LOOKUP: p_st_d = ST_IDLE;
      default:   p_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    logic [COORD_W-1:0] col, row;
    bus.probe_ready = (p_st_q == ST_IDLE);
    p_start         = bus.probe_valid && (p_st_q == ST_IDLE);
    p_seen_d        = (p_st_q == ST_DIVIDE) ? (p_seen_q | div_done[NDIV-1:0]) : '0;
    p_wall          = '0;
    p_exit          = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      col = div_quo[2*i];
      row = div_quo[2*i+1];
      if (col >= COORD_W'(COLS))      p_wall[i] = 1'b1;
      else if (row >= COORD_W'(ROWS)) p_exit[i] = 1'b1;
      else                            p_wall[i] = map_rev[row[ROW_W-1:0]][col[COL_W-1:0]];
    end
    res_valid_d = (p_st_q == ST_LOOKUP);
    res_wall_d  = (p_st_q == ST_LOOKUP) ? p_wall : res_wall_q;
    if (map_load)                             win_d = 1'b0;
    else if ((p_st_q == ST_LOOKUP) && |p_exit) win_d = 1'b1;
    else                                      win_d = win_q;
  end

  // ---------------- line channel
  req_state_e         l_st_q, l_st_d;
  logic [COORD_W-1:0] l_row;
  logic [LINE_W-1:0]  l_mask, line_data_q, line_data_d;
  logic               line_valid_q, line_valid_d;

  assign l_row = div_quo[NDIV];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) l_st_q <= ST_IDLE;
    else       l_st_q <= l_st_d;
  end

  always_comb begin
    l_st_d = l_st_q;
    case (l_st_q)
      ST_IDLE:   if (bus.line_valid_in) l_st_d = ST_DIVIDE;
      ST_DIVIDE: if (div_done[NDIV]) l_st_d = ST_LOOKUP;
      ST_LOOKUP: l_st_d = ST_IDLE;
      default:   l_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.line_ready = (l_st_q == ST_IDLE);
    l_start        = bus.line_valid_in && (l_st_q == ST_IDLE);
    l_mask         = '0;
    if (l_row < COORD_W'(ROWS))
      for (int c = 0; c < COLS; c++)
        l_mask[X_OFFSET + c*FIELD +: FIELD] = {FIELD{map_rev[l_row[ROW_W-1:0]][c]}};
    line_valid_d = (l_st_q == ST_LOOKUP);
    line_data_d  = (l_st_q == ST_LOOKUP) ? l_mask : line_data_q;
  end

  // ---------------- map select and datapath registers
  assign map_d     = map_load ? map_sel : map_q;
  assign start_x_d = START_X[map_q];
  assign start_y_d = START_Y[map_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_q        <= '0;
      start_x_q    <= START_X[0];
      start_y_q    <= START_Y[0];
      p_seen_q     <= '0;
      res_wall_q   <= '0;
      res_valid_q  <= 1'b0;
      win_q        <= 1'b0;
      line_data_q  <= '0;
      line_valid_q <= 1'b0;
    end else begin
      map_q        <= map_d;
      start_x_q    <= start_x_d;
      start_y_q    <= start_y_d;
      p_seen_q     <= p_seen_d;
      res_wall_q   <= res_wall_d;
      res_valid_q  <= res_valid_d;
      win_q        <= win_d;
      line_data_q  <= line_data_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign bus.result_valid = res_valid_q;
  assign bus.result_wall  = res_wall_q;
  assign bus.line_valid   = line_valid_q;
  assign bus.line_data    = line_data_q;
  assign win              = win_q;
  assign start_x          = start_x_q;
  assign start_y          = start_y_q;

endmodule
